// File: rtl/morse_pkg.sv
// Shared state encoding and ITU timing constants for the Morse element sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    EGAP = 2'd2,
    CGAP = 2'd3
  } state_t;

  localparam logic [2:0] DOT_UNITS    = 3'd1;
  localparam logic [2:0] DASH_UNITS   = 3'd3;
  localparam logic [2:0] EGAP_UNITS   = 3'd1;
  localparam logic [2:0] CGAP_UNITS   = 3'd3;
  localparam logic [2:0] WORD_UNITS   = 3'd7;
  localparam logic [2:0] MAX_ELEMENTS = 3'd5;

  // Mark duration in units for one element bit (1 = dash, 0 = dot).
  function automatic logic [2:0] elem_units(input logic is_dash);
    return is_dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 while running and pulses tick on the wrap.
module morse_unit_timer #(
  parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  logic [23:0] r_count;
  logic        w_wrap;

  assign w_wrap = (r_count == (UNIT_CYCLES - 24'd1));
  assign tick   = run & w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 24'd0;
    end else if (clear) begin
      // Restart on every accepted character so its first unit is full length.
      r_count <= 24'd0;
    end else if (run) begin
      if (w_wrap) r_count <= 24'd0;
      else        r_count <= r_count + 24'd1;
    end
  end

endmodule

// File: rtl/morse_element_sequencer.sv
// Pulls encoded characters over valid/ready and keys morse_out with ITU element,
// character and word timing derived from a single unit prescaler.
module morse_element_sequencer
  import morse_pkg::*;
#(
  parameter logic [23:0] UNIT_CYCLES = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       sym_space,
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_pattern,
  output logic       morse_out,
  output logic       busy
);

  state_t     r_state;
  logic [4:0] r_pattern;
  logic [2:0] r_elems;
  logic [2:0] r_units;
  logic       r_morse;

  logic w_transfer;
  logic w_tick;
  logic w_run;
  logic w_last_unit;
  logic w_len_ok;

  assign sym_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign morse_out   = r_morse;
  assign w_transfer  = sym_valid & sym_ready;
  assign w_run       = busy;
  assign w_last_unit = w_tick & (r_units == 3'd1);
  assign w_len_ok    = (sym_len != 3'd0) && (sym_len <= MAX_ELEMENTS);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(w_transfer),
    .run  (w_run),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pattern <= 5'd0;
      r_elems   <= 3'd0;
      r_units   <= 3'd0;
      r_morse   <= 1'b0;
    end else begin
      // Units count down on ticks; a state ends on the tick that finds one unit left.
      if (w_tick && (r_units != 3'd1)) begin
        r_units <= r_units - 3'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_transfer) begin
            if (sym_space) begin
              r_state <= CGAP;
              r_units <= WORD_UNITS;
              r_morse <= 1'b0;
            end else if (w_len_ok) begin
              r_pattern <= sym_pattern;
              r_elems   <= sym_len;
              r_state   <= MARK;
              r_units   <= elem_units(sym_pattern[0]);
              r_morse   <= 1'b1;
            end
          end
        end
        MARK: begin
          if (w_last_unit) begin
            r_elems <= r_elems - 3'd1;
            r_morse <= 1'b0;
            if (r_elems > 3'd1) begin
              r_pattern <= r_pattern >> 1;
              r_state   <= EGAP;
              r_units   <= EGAP_UNITS;
            end else begin
              r_state <= CGAP;
              r_units <= CGAP_UNITS;
            end
          end
        end
        EGAP: begin
          if (w_last_unit) begin
            r_state <= MARK;
            r_units <= elem_units(r_pattern[0]);
            r_morse <= 1'b1;
          end
        end
        CGAP: begin
          if (w_last_unit) begin
            r_state <= IDLE;
            r_units <= 3'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_morse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Bench: two sequencers (4-cycle and 1-cycle units) checked cycle by cycle against
// a keying waveform built from the ITU timing rules.
module tb_morse_element_sequencer;

  logic clk;
  logic rst_n;

  logic       v4, sp4, rdy4, mo4, bz4;
  logic [2:0] len4;
  logic [4:0] pat4;
  logic       v1, sp1, rdy1, mo1, bz1;
  logic [2:0] len1;
  logic [4:0] pat1;

  int total = 0;
  int bad   = 0;

  morse_element_sequencer #(.UNIT_CYCLES(24'd4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sym_valid(v4), .sym_ready(rdy4), .sym_space(sp4),
    .sym_len(len4), .sym_pattern(pat4), .morse_out(mo4), .busy(bz4)
  );

  morse_element_sequencer #(.UNIT_CYCLES(24'd1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sym_valid(v1), .sym_ready(rdy1), .sym_space(sp1),
    .sym_len(len1), .sym_pattern(pat1), .morse_out(mo1), .busy(bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected keying after a transfer, one entry per cycle, from the timing rules.
  task automatic build_wave(input int u, input bit space, input logic [2:0] len,
                            input logic [4:0] pat, output bit wave[$]);
    wave.delete();
    if (space) begin
      repeat (7 * u) wave.push_back(1'b0);
    end else if (len >= 1 && len <= 5) begin
      for (int i = 0; i < int'(len); i++) begin
        repeat ((pat[i] ? 3 : 1) * u) wave.push_back(1'b1);
        if (i < int'(len) - 1) repeat (u) wave.push_back(1'b0);
      end
      repeat (3 * u) wave.push_back(1'b0);
    end
  endtask

  task automatic drive(input bit sel1, input bit v, input bit sp,
                       input logic [2:0] ln, input logic [4:0] pt);
    if (sel1) begin v1 = v; sp1 = sp; len1 = ln; pat1 = pt; end
    else      begin v4 = v; sp4 = sp; len4 = ln; pat4 = pt; end
  endtask

  task automatic run_char(input bit sel1, input bit space, input logic [2:0] len,
                          input logic [4:0] pat, input bit hold_valid, input string name);
    bit wave[$];
    bit hold;
    int u;
    u = sel1 ? 1 : 4;
    build_wave(u, space, len, pat, wave);
    hold = hold_valid && (wave.size() != 0);
    @(negedge clk);
    check({name, ".ready_before"}, sel1 ? rdy1 : rdy4, 1);
    drive(sel1, 1'b1, space, len, pat);
    @(posedge clk);
    #1;
    if (hold) drive(sel1, 1'b1, 1'($urandom), 3'($urandom), 5'($urandom));
    else      drive(sel1, 1'b0, 1'b0, 3'd0, 5'd0);
    for (int k = 0; k < wave.size(); k++) begin
      @(negedge clk);
      check({name, ".morse"}, sel1 ? mo1 : mo4, wave[k]);
      check({name, ".busy"},  sel1 ? bz1 : bz4, 1);
      check({name, ".ready"}, sel1 ? rdy1 : rdy4, 0);
      if (hold) drive(sel1, 1'b1, 1'($urandom), 3'($urandom), 5'($urandom));
    end
    @(negedge clk);
    check({name, ".ready_end"}, sel1 ? rdy1 : rdy4, 1);
    check({name, ".busy_end"},  sel1 ? bz1 : bz4, 0);
    check({name, ".morse_end"}, sel1 ? mo1 : mo4, 0);
    drive(sel1, 1'b0, 1'b0, 3'd0, 5'd0);
    $display("%s: unit=%0d space=%0d len=%0d pat=%b hold=%0d cycles=%0d", name, u,
             space, len, pat, hold, wave.size());
  endtask

  initial begin
    bit       rs;
    bit       rh;
    bit       rsel;
    logic [2:0] rl;
    logic [4:0] rp;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
    #1;
    check("reset.ready4", rdy4, 1);
    check("reset.busy4",  bz4,  0);
    check("reset.morse4", mo4,  0);
    check("reset.ready1", rdy1, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_char(1'b0, 1'b0, 3'd1, 5'b00000, 1'b0, "E");
    run_char(1'b0, 1'b0, 3'd2, 5'b00010, 1'b0, "A");
    run_char(1'b0, 1'b1, 3'd3, 5'b10101, 1'b0, "SPACE");
    run_char(1'b0, 1'b0, 3'd0, 5'b11111, 1'b0, "LEN0");
    run_char(1'b0, 1'b0, 3'd6, 5'b00000, 1'b0, "LEN6");
    run_char(1'b1, 1'b0, 3'd5, 5'b11111, 1'b1, "ZERO_U1");

    // Abort mid-mark: outputs must fall as soon as rst_n drops, before any edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'd3, 5'b00101);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("abort.pre_morse", mo4, 1);
    rst_n = 1'b0;
    #1;
    check("abort.morse", mo4,  0);
    check("abort.busy",  bz4,  0);
    check("abort.ready", rdy4, 1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("ABORT: reset during mark");
    run_char(1'b0, 1'b0, 3'd1, 5'b00001, 1'b0, "T_AFTER_ABORT");

    for (int n = 0; n < 40; n++) begin
      rsel = 1'($urandom);
      rs   = ($urandom_range(0, 7) == 0);
      rl   = 3'($urandom_range(0, 7));
      rp   = 5'($urandom);
      rh   = 1'($urandom);
      run_char(rsel, rs, rl, rp, rh, "RAND");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
